// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall and flush steering for a 5-stage pipe.
// Optional MEMWAIT state compiled in with `define PIPE_CTRL_MEMWAIT_EN.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    input  logic       idex_mem_r,
    input  logic [4:0] idex_rd_addr,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    input  logic       exmem_syscall,
    input  logic       exmem_eret,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       cu_stall,
    output logic       exmem_stall,
    output logic       ifid_flush,
    output logic       cu_flush,
    output logic       exmem_flush,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        EXCFLUSH = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_exc;
    logic             w_load_use;

    assign w_exc = exmem_syscall | exmem_eret;

    // Load in EX writes a register the ID instruction reads; r0 never hazards.
    assign w_load_use = idex_mem_r && (idex_rd_addr != 5'd0) &&
                        ((idex_rd_addr == id_rs_addr) ||
                         (id_uses_rt && (idex_rd_addr == id_rt_addr)));

`ifndef PIPE_CTRL_MEMWAIT_EN
    logic w_unused_mem_busy;
    assign w_unused_mem_busy = mem_busy;
`endif

    assign state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // An exception in MEM outranks everything: it drives the flush pattern and reloads the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        cu_stall    = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        cu_flush    = 1'b0;
        exmem_flush = 1'b0;

        case (r_state)
            RUN: begin
                if (w_exc) begin
                    w_state_nxt = EXCFLUSH;
                    w_cnt_nxt   = CNT_LOAD;
                    ifid_flush  = 1'b1;
                    cu_flush    = 1'b1;
                    exmem_flush = 1'b1;
`ifdef PIPE_CTRL_MEMWAIT_EN
                end else if (mem_busy) begin
                    w_state_nxt = MEMWAIT;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    cu_stall    = 1'b1;
                    exmem_stall = 1'b1;
`endif
                end else if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    cu_flush   = 1'b1;
                end else if (w_load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    cu_flush   = 1'b1;
                end
            end
`ifdef PIPE_CTRL_MEMWAIT_EN
            MEMWAIT: begin
                if (w_exc) begin
                    w_state_nxt = EXCFLUSH;
                    w_cnt_nxt   = CNT_LOAD;
                    ifid_flush  = 1'b1;
                    cu_flush    = 1'b1;
                    exmem_flush = 1'b1;
                end else begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    cu_stall    = 1'b1;
                    exmem_stall = 1'b1;
                    if (!mem_busy) begin
                        w_state_nxt = RUN;
                    end
                end
            end
`endif
            EXCFLUSH: begin
                ifid_flush  = 1'b1;
                cu_flush    = 1'b1;
                exmem_flush = 1'b1;
                if (w_exc) begin
                    w_cnt_nxt = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                // Unreachable encodings: outputs stay quiet, recover to RUN.
                w_state_nxt = w_exc ? EXCFLUSH : RUN;
                w_cnt_nxt   = w_exc ? CNT_LOAD : '0;
            end
        endcase

        if (reset) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            cu_stall    = 1'b0;
            exmem_stall = 1'b0;
            ifid_flush  = 1'b0;
            cu_flush    = 1'b0;
            exmem_flush = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
`ifdef PIPE_CTRL_MEMWAIT_EN
    localparam bit MW_EN = 1'b1;
`else
    localparam bit MW_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rt;
    logic       idex_mem_r;
    logic [4:0] idex_rd_addr;
    logic       ex_branch_taken;
    logic       mem_busy;
    logic       exmem_syscall;
    logic       exmem_eret;
    logic       pc_stall;
    logic       ifid_stall;
    logic       cu_stall;
    logic       exmem_stall;
    logic       ifid_flush;
    logic       cu_flush;
    logic       exmem_flush;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 run, 1 waiting on memory, 2 flushing; flush_left = flush cycles still to go.
    int m_mode = 0;
    int m_left = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_uses_rt     (id_uses_rt),
        .idex_mem_r     (idex_mem_r),
        .idex_rd_addr   (idex_rd_addr),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .exmem_syscall  (exmem_syscall),
        .exmem_eret     (exmem_eret),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .cu_stall       (cu_stall),
        .exmem_stall    (exmem_stall),
        .ifid_flush     (ifid_flush),
        .cu_flush       (cu_flush),
        .exmem_flush    (exmem_flush),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Expected {pc_stall, ifid_stall, cu_stall, exmem_stall, ifid_flush, cu_flush, exmem_flush}.
    function automatic logic [6:0] model_out();
        bit hazard;
        hazard = idex_mem_r && (idex_rd_addr != 0) &&
                 (idex_rd_addr == id_rs_addr || (id_uses_rt && idex_rd_addr == id_rt_addr));
        if (reset)                          return 7'b000_0000;
        if (exmem_syscall || exmem_eret)    return 7'b000_0111;
        if (m_mode == 2)                    return 7'b000_0111;
        if (m_mode == 1)                    return 7'b111_1000;
        if (MW_EN && mem_busy)              return 7'b111_1000;
        if (ex_branch_taken)                return 7'b000_0110;
        if (hazard)                         return 7'b110_0010;
        return 7'b000_0000;
    endfunction

    task automatic model_edge();
        if (exmem_syscall || exmem_eret) begin
            m_mode = 2;
            m_left = FLUSH_CYCLES;
        end else if (m_mode == 0) begin
            if (MW_EN && mem_busy) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!mem_busy) m_mode = 0;
        end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic compare(input string tag);
        check_eq({tag, ".state"}, 32'(state), 32'(m_mode));
        check_eq({tag, ".ctl"},
                 32'({pc_stall, ifid_stall, cu_stall, exmem_stall, ifid_flush, cu_flush, exmem_flush}),
                 32'(model_out()));
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        m_mode = 0;
        m_left = 0;
        compare({tag, ".async"});
        @(negedge clk);
        compare({tag, ".held"});
        reset = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_addr      = 5'd0;
        id_rt_addr      = 5'd0;
        id_uses_rt      = 1'b0;
        idex_mem_r      = 1'b0;
        idex_rd_addr    = 5'd0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
        exmem_syscall   = 1'b0;
        exmem_eret      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // Reset with a load-use hazard present: outputs must still be quiet.
        reset        = 1'b1;
        idex_mem_r   = 1'b1;
        idex_rd_addr = 5'd7;
        id_rs_addr   = 5'd7;
        #1;
        compare("reset");
        @(negedge clk);
        compare("reset.held");
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        cycle("post_reset");

        idex_mem_r = 1'b1; idex_rd_addr = 5'd5; id_rs_addr = 5'd5;
        cycle("load_use");
        idex_mem_r = 1'b0;
        cycle("load_use.after");

        idex_mem_r = 1'b1; id_uses_rt = 1'b1; idex_rd_addr = 5'd9; id_rs_addr = 5'd1; id_rt_addr = 5'd9;
        cycle("load_use_rt");
        id_uses_rt = 1'b0;
        cycle("rt_unused");

        idle_inputs();
        idex_mem_r = 1'b1; idex_rd_addr = 5'd0; id_rs_addr = 5'd0;
        cycle("zero_reg");
        idle_inputs();

        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cycle("memwait");
        mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) cycle("memwait.exit");

        mem_busy = 1'b1;
        cycle("exc_prio.busy");
        cycle("exc_prio.wait");
        exmem_syscall = 1'b1;
        cycle("exc_prio.sys");
        exmem_syscall = 1'b0;
        for (int i = 0; i < 4; i++) cycle("exc_prio.flush");
        mem_busy = 1'b0;
        cycle("exc_prio.end");

        idex_mem_r = 1'b1; idex_rd_addr = 5'd3; id_rs_addr = 5'd3; ex_branch_taken = 1'b1;
        cycle("branch_over_lu");
        ex_branch_taken = 1'b0;
        cycle("lu_after_branch");
        idle_inputs();

        exmem_eret = 1'b1;
        cycle("eret");
        exmem_eret = 1'b0;
        cycle("eret.flush");
        pulse_reset("mid_flush_rst");
        for (int i = 0; i < 3; i++) cycle("after_rst");

        for (int n = 0; n < 800; n++) begin
            id_rs_addr      = 5'($urandom_range(0, 3));
            id_rt_addr      = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            idex_mem_r      = 1'($urandom_range(0, 1));
            idex_rd_addr    = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_busy        = ($urandom_range(0, 3) == 0);
            exmem_syscall   = ($urandom_range(0, 19) == 0);
            exmem_eret      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 79) == 0) pulse_reset("rand_rst");
            else cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
